// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the parametrised two-port SRAM model.
package sram_pkg;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    localparam int MAX_W = 256;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Active-low slice mask in, active-high per-bit enable out
    function automatic logic [MAX_W-1:0] mask_expand(input logic [MAX_W-1:0] wmb, input int gran);
        logic [MAX_W-1:0] en;
        logic [MAX_W-1:0] bits;
        logic [MAX_W-1:0] slice;
        en    = '0;
        bits  = wmb;
        slice = {MAX_W{1'b1}} >> (MAX_W - gran);
        for (int k = 0; k < MAX_W; k++) begin
            if (!bits[0]) en = en | (slice << (k * gran));
            bits = bits >> 1;
        end
        return en;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Per-port read output register chain; one or two stages selected by READ_LAT.
module sram_rd_pipe #(
    parameter int WIDTH    = 4,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             re,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] data_p1;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] data_p0;
            logic             vld_p0;

            // stage 0: array sample; stage 1: output, loaded only behind a valid read
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_p0 <= '0;
                    vld_p0  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    vld_p0 <= re;
                    if (re)     data_p0 <= rdata;
                    if (vld_p0) data_p1 <= data_p0;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n)  data_p1 <= '0;
                else if (re) data_p1 <= rdata;
            end
        end
    endgenerate

    assign dout = data_p1;

endmodule

// File: rtl/sram2rw_param.sv
// Two-port read/write SRAM behavioural model with masked writes, zero-init sweep and read pipeline.
module sram2rw_param
    import sram_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int DEPTH     = 16,
    parameter  int MASK_GRAN = 1,
    parameter  int READ_LAT  = 1,
    parameter  int INIT_ZERO = 1,
    localparam int AW        = clog2(DEPTH),
    localparam int MW        = WIDTH / MASK_GRAN
) (
    input  logic             CE,
    input  logic             RSTB,
    input  logic             CSB1,
    input  logic             CSB2,
    input  logic             WEB1,
    input  logic             WEB2,
    input  logic             OEB1,
    input  logic             OEB2,
    input  logic [AW-1:0]    A1,
    input  logic [AW-1:0]    A2,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [MW-1:0]    WMB1,
    input  logic [MW-1:0]    WMB2,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic             INIT_DONE,
    output logic             COLL
);

    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state, state_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic             done_nxt, coll_nxt;
    logic             ready, in1, in2, re1, re2, we1, we2, wcoll;
    logic [WIDTH-1:0] en1, en2, rdata1, rdata2;

    assign ready  = (state == ST_READY);
    assign in1    = ({1'b0, A1} < DEPTH_L);
    assign in2    = ({1'b0, A2} < DEPTH_L);
    assign re1    = ready & ~CSB1 & ~OEB1;
    assign re2    = ready & ~CSB2 & ~OEB2;
    assign we1    = ready & ~CSB1 & ~WEB1 & in1;
    assign we2    = ready & ~CSB2 & ~WEB2 & in2;
    assign wcoll  = we1 & we2 & (A1 == A2);
    assign en1    = WIDTH'(mask_expand(MAX_W'(WMB1), MASK_GRAN));
    assign en2    = WIDTH'(mask_expand(MAX_W'(WMB2), MASK_GRAN));
    assign rdata1 = in1 ? mem[A1] : '0;
    assign rdata2 = in2 ? mem[A2] : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = INIT_DONE;
        coll_nxt  = wcoll;
        case (state)
            ST_INIT: begin
                if (cnt == LAST) begin
                    state_nxt = ST_READY;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: done_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CE) begin
        if (!RSTB) begin
            state     <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            cnt       <= '0;
            INIT_DONE <= 1'b0;
            COLL      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            INIT_DONE <= done_nxt;
            COLL      <= coll_nxt;
        end
    end

    // Port 1 owns any slice both ports enable on a shared address
    always_ff @(posedge CE) begin
        if (RSTB) begin
            if (state == ST_INIT) begin
                mem[cnt] <= '0;
            end else if (wcoll) begin
                mem[A1] <= (mem[A1] & ~(en1 | en2)) | (I1 & en1) | (I2 & en2 & ~en1);
            end else begin
                if (we1) mem[A1] <= (mem[A1] & ~en1) | (I1 & en1);
                if (we2) mem[A2] <= (mem[A2] & ~en2) | (I2 & en2);
            end
        end
    end

    sram_rd_pipe #(.WIDTH(WIDTH), .READ_LAT(READ_LAT)) u_pipe1 (
        .clk   (CE),
        .rst_n (RSTB),
        .re    (re1),
        .rdata (rdata1),
        .dout  (O1)
    );

    sram_rd_pipe #(.WIDTH(WIDTH), .READ_LAT(READ_LAT)) u_pipe2 (
        .clk   (CE),
        .rst_n (RSTB),
        .re    (re2),
        .rdata (rdata2),
        .dout  (O2)
    );

endmodule

// File: tb/tb_sram2rw_param.sv
// Directed bench for sram2rw_param: 16-deep latency-1 and latency-2 instances plus a 12-deep instance.
module tb_sram2rw_param;

    typedef struct {
        logic       csb;
        logic       web;
        logic       oeb;
        logic [3:0] a;
        logic [3:0] i;
        logic [3:0] wmb;
    } op_t;

    typedef struct {
        op_t        p1;
        op_t        p2;
        logic [3:0] eo1;
        logic [3:0] eo2;
        logic       ecoll;
    } vec_t;

    logic       clk, rstb, rstb_c;
    logic       csb1, web1, oeb1, csb2, web2, oeb2;
    logic [3:0] a1, a2, i1, i2, wmb1, wmb2;
    logic [3:0] o1_a, o2_a, o1_b, o2_b, o1_c, o2_c;
    logic       done_a, done_b, done_c, coll_a, coll_b, coll_c;

    int errors = 0;
    int checks = 0;

    sram2rw_param #(.WIDTH(4), .DEPTH(16), .MASK_GRAN(1), .READ_LAT(1), .INIT_ZERO(1)) u_a (
        .CE(clk), .RSTB(rstb), .CSB1(csb1), .CSB2(csb2), .WEB1(web1), .WEB2(web2),
        .OEB1(oeb1), .OEB2(oeb2), .A1(a1), .A2(a2), .I1(i1), .I2(i2),
        .WMB1(wmb1), .WMB2(wmb2), .O1(o1_a), .O2(o2_a), .INIT_DONE(done_a), .COLL(coll_a)
    );

    sram2rw_param #(.WIDTH(4), .DEPTH(16), .MASK_GRAN(1), .READ_LAT(2), .INIT_ZERO(1)) u_b (
        .CE(clk), .RSTB(rstb), .CSB1(csb1), .CSB2(csb2), .WEB1(web1), .WEB2(web2),
        .OEB1(oeb1), .OEB2(oeb2), .A1(a1), .A2(a2), .I1(i1), .I2(i2),
        .WMB1(wmb1), .WMB2(wmb2), .O1(o1_b), .O2(o2_b), .INIT_DONE(done_b), .COLL(coll_b)
    );

    sram2rw_param #(.WIDTH(4), .DEPTH(12), .MASK_GRAN(1), .READ_LAT(1), .INIT_ZERO(1)) u_c (
        .CE(clk), .RSTB(rstb_c), .CSB1(csb1), .CSB2(csb2), .WEB1(web1), .WEB2(web2),
        .OEB1(oeb1), .OEB2(oeb2), .A1(a1), .A2(a2), .I1(i1), .I2(i2),
        .WMB1(wmb1), .WMB2(wmb2), .O1(o1_c), .O2(o2_c), .INIT_DONE(done_c), .COLL(coll_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic op_t nop();
        op_t o;
        o.csb = 1'b1; o.web = 1'b1; o.oeb = 1'b1; o.a = 4'h0; o.i = 4'h0; o.wmb = 4'hF;
        return o;
    endfunction

    function automatic op_t rd(input logic [3:0] a);
        op_t o;
        o.csb = 1'b0; o.web = 1'b1; o.oeb = 1'b0; o.a = a; o.i = 4'h0; o.wmb = 4'hF;
        return o;
    endfunction

    function automatic op_t wr(input logic [3:0] a, input logic [3:0] i, input logic [3:0] m);
        op_t o;
        o.csb = 1'b0; o.web = 1'b0; o.oeb = 1'b1; o.a = a; o.i = i; o.wmb = m;
        return o;
    endfunction

    function automatic vec_t mk(input op_t p1, input op_t p2, input logic [3:0] eo1,
                                input logic [3:0] eo2, input logic ecoll);
        vec_t v;
        v.p1 = p1; v.p2 = p2; v.eo1 = eo1; v.eo2 = eo2; v.ecoll = ecoll;
        return v;
    endfunction

    task automatic apply(input op_t p1, input op_t p2);
        csb1 = p1.csb; web1 = p1.web; oeb1 = p1.oeb; a1 = p1.a; i1 = p1.i; wmb1 = p1.wmb;
        csb2 = p2.csb; web2 = p2.web; oeb2 = p2.oeb; a2 = p2.a; i2 = p2.i; wmb2 = p2.wmb;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    vec_t tbl [35];
    op_t  csb_off;

    initial begin
        logic [3:0] prev_o1, prev_o2;
        int         n;

        for (int i = 0; i < 16; i++)
            tbl[i] = mk(rd(4'(i)), rd(4'(15 - i)), 4'h0, 4'h0, 1'b0);
        csb_off     = wr(4'd3, 4'h5, 4'h0);
        csb_off.csb = 1'b1;
        csb_off.oeb = 1'b0;
        tbl[16] = mk(wr(4'd3, 4'hA, 4'h0),  nop(),                   4'h0, 4'h0, 1'b0);
        tbl[17] = mk(nop(),                  rd(4'd3),                4'h0, 4'hA, 1'b0);
        tbl[18] = mk(nop(),                  nop(),                   4'h0, 4'hA, 1'b0);
        tbl[19] = mk(wr(4'd5, 4'hF, 4'h0),  nop(),                   4'h0, 4'hA, 1'b0);
        tbl[20] = mk(wr(4'd5, 4'h0, 4'hA),  nop(),                   4'h0, 4'hA, 1'b0);
        tbl[21] = mk(rd(4'd5),               nop(),                   4'hA, 4'hA, 1'b0);
        tbl[22] = mk(wr(4'd7, 4'h3, 4'h0),  wr(4'd7, 4'hC, 4'h0),   4'hA, 4'hA, 1'b1);
        tbl[23] = mk(rd(4'd7),               nop(),                   4'h3, 4'hA, 1'b0);
        tbl[24] = mk(wr(4'd7, 4'h3, 4'hC),  wr(4'd7, 4'hC, 4'h0),   4'h3, 4'hA, 1'b1);
        tbl[25] = mk(nop(),                  rd(4'd7),                4'h3, 4'hF, 1'b0);
        tbl[26] = mk(wr(4'd2, 4'h1, 4'h0),  nop(),                   4'h3, 4'hF, 1'b0);
        tbl[27] = mk(wr(4'd2, 4'h9, 4'h0),  rd(4'd2),                4'h3, 4'h1, 1'b0);
        tbl[28] = mk(nop(),                  rd(4'd2),                4'h3, 4'h9, 1'b0);
        tbl[29] = mk(rd(4'd4),               nop(),                   4'h0, 4'h9, 1'b0);
        tbl[30] = mk(csb_off,                rd(4'd3),                4'h0, 4'hA, 1'b0);
        tbl[31] = mk(rd(4'd3),               rd(4'd5),                4'hA, 4'hA, 1'b0);
        tbl[32] = mk(rd(4'd2),               rd(4'd7),                4'h9, 4'hF, 1'b0);
        tbl[33] = mk(wr(4'd8, 4'h6, 4'h0),  wr(4'd9, 4'h5, 4'h0),   4'h9, 4'hF, 1'b0);
        tbl[34] = mk(rd(4'd8),               rd(4'd9),                4'h6, 4'h5, 1'b0);

        // Reset
        apply(nop(), nop());
        rstb   = 1'b0;
        rstb_c = 1'b0;
        step();
        step();
        chk("rst_o1_a", 32'(o1_a), 32'h0);
        chk("rst_o2_a", 32'(o2_a), 32'h0);
        chk("rst_o1_b", 32'(o1_b), 32'h0);
        chk("rst_done_a", 32'(done_a), 32'h0);
        chk("rst_coll_a", 32'(coll_a), 32'h0);
        chk("rst_done_c", 32'(done_c), 32'h0);

        // Init sweep; a write issued on the last sweep cycle must be ignored
        rstb   = 1'b1;
        rstb_c = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            if (e == 16) apply(wr(4'd4, 4'hF, 4'h0), nop());
            step();
            apply(nop(), nop());
            chk($sformatf("init_done_a_e%0d", e), 32'(done_a), 32'(e == 16));
            chk($sformatf("init_done_b_e%0d", e), 32'(done_b), 32'(e == 16));
            chk($sformatf("init_done_c_e%0d", e), 32'(done_c), 32'(e >= 12));
        end
        chk("init_o1_a", 32'(o1_a), 32'h0);
        chk("init_coll_a", 32'(coll_a), 32'h0);

        // Vector table; the latency-2 instance trails the latency-1 one by a row
        prev_o1 = 4'h0;
        prev_o2 = 4'h0;
        for (int r = 0; r < 35; r++) begin
            apply(tbl[r].p1, tbl[r].p2);
            step();
            chk($sformatf("row%0d_o1_l1", r), 32'(o1_a), 32'(tbl[r].eo1));
            chk($sformatf("row%0d_o2_l1", r), 32'(o2_a), 32'(tbl[r].eo2));
            chk($sformatf("row%0d_coll_l1", r), 32'(coll_a), 32'(tbl[r].ecoll));
            chk($sformatf("row%0d_o1_l2", r), 32'(o1_b), 32'(prev_o1));
            chk($sformatf("row%0d_o2_l2", r), 32'(o2_b), 32'(prev_o2));
            chk($sformatf("row%0d_coll_l2", r), 32'(coll_b), 32'(tbl[r].ecoll));
            prev_o1 = tbl[r].eo1;
            prev_o2 = tbl[r].eo2;
        end

        // Out-of-range address on the 12-deep instance
        apply(wr(4'd13, 4'hF, 4'h0), wr(4'd13, 4'h5, 4'h0));
        step();
        chk("oor_coll_c", 32'(coll_c), 32'h0);
        chk("inrange_coll_a", 32'(coll_a), 32'h1);
        apply(rd(4'd3), nop());
        step();
        chk("oor_pre_o1_c", 32'(o1_c), 32'hA);
        apply(rd(4'd13), rd(4'd13));
        step();
        chk("oor_rd_o1_c", 32'(o1_c), 32'h0);
        chk("oor_rd_o2_c", 32'(o2_c), 32'h0);
        chk("coll_data_o1_a", 32'(o1_a), 32'hF);
        apply(nop(), nop());

        // Reset at sweep count 8 restarts the sweep
        rstb_c = 1'b0;
        step();
        rstb_c = 1'b1;
        for (int k = 0; k < 8; k++) step();
        rstb_c = 1'b0;
        step();
        chk("mid_rst_done_c", 32'(done_c), 32'h0);
        chk("mid_rst_o1_c", 32'(o1_c), 32'h0);
        chk("mid_rst_coll_c", 32'(coll_c), 32'h0);
        rstb_c = 1'b1;
        n = 0;
        while (!done_c && n < 40) begin
            step();
            n++;
        end
        chk("restart_edges_c", 32'(n), 32'd12);
        apply(rd(4'd3), rd(4'd5));
        step();
        chk("swept_o1_c", 32'(o1_c), 32'h0);
        chk("swept_o2_c", 32'(o2_c), 32'h0);
        apply(nop(), nop());
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
